// File: rtl/exposure_timer_if.sv
// Control/status bundle for exposure_timer: the controller drives Start/Stop and
// configuration, the timer returns overflow and status.
interface exposure_timer_if #(
  parameter int WIDTH          = 5,
  parameter int PRESCALE_WIDTH = 4
);
  logic                      Start;
  logic                      Stop;
  logic                      Mode;
  logic [WIDTH-1:0]          Load_value;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      Ovf_clear;
  logic                      Ovf;
  logic                      Ovf_flag;
  logic                      Busy;
  logic [WIDTH-1:0]          Count;

  modport master (
    output Start, Stop, Mode, Load_value, Prescale, Ovf_clear,
    input  Ovf, Ovf_flag, Busy, Count
  );

  modport slave (
    input  Start, Stop, Mode, Load_value, Prescale, Ovf_clear,
    output Ovf, Ovf_flag, Busy, Count
  );
endinterface

// File: rtl/exposure_timer.sv
// Prescaled up-counter with latched terminal count, one-shot/periodic modes,
// registered overflow pulse and sticky overflow flag.
module exposure_timer #(
  parameter int WIDTH          = 5,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  exposure_timer_if.slave    bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state;
  logic [WIDTH-1:0]          t_l;
  logic [PRESCALE_WIDTH-1:0] p_l;
  logic                      mode_l;
  logic [PRESCALE_WIDTH-1:0] pre;
  logic [WIDTH-1:0]          count;
  logic                      ovf;
  logic                      ovf_flag;
  logic                      busy;

  logic tick;
  logic term;
  logic ovf_set;

  assign tick    = (pre == p_l);
  assign term    = tick && (count == t_l);
  // Stop and restart both suppress a coinciding terminal tick.
  assign ovf_set = (state == RUN) && !bus.Stop && !bus.Start && term;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      t_l      <= '0;
      p_l      <= '0;
      mode_l   <= 1'b0;
      pre      <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      ovf_flag <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ovf <= ovf_set;
      if (ovf_set)            ovf_flag <= 1'b1;
      else if (bus.Ovf_clear) ovf_flag <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.Start && !bus.Stop) begin
            state  <= RUN;
            busy   <= 1'b1;
            t_l    <= bus.Load_value;
            p_l    <= bus.Prescale;
            mode_l <= bus.Mode;
            count  <= '0;
            pre    <= '0;
          end
        end
        RUN: begin
          if (bus.Stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= '0;
            pre   <= '0;
          end else if (bus.Start) begin
            t_l    <= bus.Load_value;
            p_l    <= bus.Prescale;
            mode_l <= bus.Mode;
            count  <= '0;
            pre    <= '0;
          end else if (tick) begin
            pre <= '0;
            if (term) begin
              count <= '0;
              if (!mode_l) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              count <= count + WIDTH'(1);
            end
          end else begin
            pre <= pre + PRESCALE_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Ovf      = ovf;
  assign bus.Ovf_flag = ovf_flag;
  assign bus.Busy     = busy;
  assign bus.Count    = count;

endmodule

// File: doc/exposure_timer.md
# exposure_timer

Parametrised successor to the single-channel exposure timer: a programmable up-counter that measures a latched terminal count of prescaled ticks and signals overflow. Adds configurable width, a clock prescaler, one-shot/periodic modes, explicit Stop, a sticky overflow flag with clear, and status outputs. Sits between the control FSM, which drives Start/Stop, and the exposure/readout sequencing, which consumes Ovf.

## Interface
- WIDTH, 5: width of Load_value and Count.
- PRESCALE_WIDTH, 4: width of Prescale.
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-low; low clears all state immediately.
- Start  in  1  synchronous start/restart request, sampled each edge.
- Stop  in  1  synchronous abort request, sampled each edge.
- Mode  in  1  0 = one-shot, 1 = periodic; latched on Start.
- Load_value  in  WIDTH  terminal count T; latched on Start.
- Prescale  in  PRESCALE_WIDTH  P; one tick every P+1 clocks; latched on Start.
- Ovf_clear  in  1  clears Ovf_flag.
- Ovf  out  1  one-cycle overflow pulse (registered).
- Ovf_flag  out  1  sticky overflow indication.
- Busy  out  1  high while in RUN.
- Count  out  WIDTH  current tick count.

## Operation
- States: IDLE, RUN. Internal regs: T_l, P_l, Mode_l, prescaler Pre (PRESCALE_WIDTH bits).
- IDLE: Count=0, Pre=0, Busy=0. Start=1 and Stop=0 -> RUN; latch T_l, P_l, Mode_l; Count<=0, Pre<=0.
- RUN: tick = (Pre == P_l). Non-tick edge: Pre<=Pre+1. Tick edge: Pre<=0, and
  - Count < T_l: Count<=Count+1.
  - Count == T_l: Ovf<=1 for one cycle; Ovf_flag<=1; Count<=0; Mode_l=1 stays in RUN, Mode_l=0 -> IDLE.
- Start in RUN (Stop=0): restart — re-latch inputs, Count<=0, Pre<=0, no Ovf, even if a tick coincides.
- Stop in RUN: -> IDLE, Count<=0, Pre<=0, no Ovf even if a terminal tick coincides. Stop in IDLE: no effect.
- Start and Stop same edge: Stop wins.
- Load_value, Prescale, Mode changes outside a Start edge are ignored.
- Ovf_flag: set on each Ovf; cleared by Ovf_clear; set and clear same edge -> set wins.
- Count arithmetic unsigned, WIDTH bits; Count never exceeds T_l, so no wrap. T=2^WIDTH-1 and P=2^PRESCALE_WIDTH-1 are legal.
- T=0: Ovf on the first tick.

## Timing
- Reset low: Ovf=0, Ovf_flag=0, Busy=0, Count=0, state IDLE, Pre=0, latched regs 0, asynchronously. First Start is honoured on the first rising edge after Reset deasserts.
- Start sampled at edge e0: Busy=1 and Count=0 after e0.
- Tick edges at e0+k(P+1), k>=1. Count=k after tick k (k<=T).
- Ovf high for exactly the cycle following edge e0+(T+1)(P+1); Ovf_flag high from the same cycle.
- One-shot: Busy falls in the same cycle Ovf rises.
- Periodic: subsequent Ovf pulses every (T+1)(P+1) cycles, no gap cycle.
- Stop at edge e: Busy=0, Count=0 after e.
- Ovf never high two consecutive cycles unless T=0 and P=0 in periodic mode (then high every cycle).

## Test plan
- Reset mid-RUN: WIDTH=5, T=10, P=0, Start, pull Reset low after 4 cycles -> all outputs 0 immediately; no Ovf after release.
- One-shot, T=5, P=0: Start at e0 -> Count steps 1..5, Ovf single pulse after e0+6, Busy low from then, Ovf_flag stays 1 until Ovf_clear.
- Periodic, T=3, P=2: Start -> Ovf pulses after e0+12, e0+24, e0+36; Count runs 0..3 repeatedly; Stop -> Busy 0, Count 0, no further Ovf.
- Edge values: T=31, P=15, one-shot -> Ovf after exactly 512 cycles; T=0, P=0, periodic -> Ovf high every cycle.
- Restart/abort: Start again at Count=2 of T=4 -> Count 0, Ovf delayed to restart+5(P+1); Start+Stop same edge -> IDLE; Stop on terminal tick -> no Ovf.
- Flag priority: Ovf_clear asserted on the overflow edge -> Ovf_flag=1; Ovf_clear next cycle -> 0. Load_value change during RUN -> no effect on Ovf timing.
